regfile_mp: RTL and testbench

// - Parametrised multi-port GPR file for the ID stage; next generation of the 2R/1W 32x32 regfile.
// - Adds N read ports, N write ports with same-cycle forwarding, and a hardware clear sequencer.
// - The sequencer zeroes every entry after reset or on request; ready gates pipeline issue.

---
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port general purpose register file for the ID stage.
// NR combinational read ports with same-cycle forwarding from NW write
// ports, and a clear sequencer that zeroes every entry one per cycle after
// reset or on request. 'ready' gates pipeline issue.
//
// Ports
//   clk      in   1        clock, rising edge
//   rst      in   1        synchronous reset, active high
//   clr      in   1        request full clear (honoured only while running)
//   ready    out  1        1 = file usable, 0 = reset or clearing
//   wr_drop  out  1        one-cycle flag: a write was attempted while not running
//   we       in   NW       write enable per port
//   waddr    in   NW*AW    write address, port i = [i*AW +: AW]
//   wdata    in   NW*DW    write data,    port i = [i*DW +: DW]
//   re       in   NR       read enable per port
//   raddr    in   NR*AW    read address,  port j = [j*AW +: AW]
//   rdata    out  NR*DW    read data,     port j = [j*DW +: DW], combinational
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             ready,
  output logic             wr_drop,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata
);

  localparam logic [0:0]    ST_CLEAR  = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  // One extra bit so the range compare is meaningful even when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  logic [0:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_wr_drop;
  logic [DW-1:0] r_mem [0:DEPTH-1];

  logic          w_run;
  logic [AW-1:0] w_waddr [NW];
  logic [DW-1:0] w_wdata [NW];
  logic [NW-1:0] w_wen;

  // Reset overrides the state register immediately for reads and writes.
  assign w_run = (r_state == ST_RUN) && !rst;

  // Per write port: effective enable after range, zero-register and run gating.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_wport
      assign w_waddr[gi] = waddr[gi*AW +: AW];
      assign w_wdata[gi] = wdata[gi*DW +: DW];
      assign w_wen[gi]   = w_run && we[gi]
                           && ({1'b0, w_waddr[gi]} < DEPTH_EXT)
                           && !((ZERO_REG != 0) && (w_waddr[gi] == '0));
    end
  endgenerate

  // Storage has no reset; the clear sequencer defines its contents.
  // Ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == ST_CLEAR)) begin
      r_mem[r_cnt] <= '0;
    end
    for (int i = 0; i < NW; i++) begin
      if (w_wen[i]) begin
        r_mem[w_waddr[i]] <= w_wdata[i];
      end
    end
  end

  // Clear / run sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= (|we) && (r_state != ST_RUN);
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign ready   = (r_state == ST_RUN);
  assign wr_drop = r_wr_drop;

  // Read ports: zero when not usable, otherwise forwarded write data (highest
  // port wins) or the stored value.
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rport
      logic [AW-1:0] w_ra;
      logic [DW-1:0] w_rd;

      assign w_ra = raddr[gi*AW +: AW];

      always_comb begin
        w_rd = '0;
        if (w_run && re[gi]
            && !((ZERO_REG != 0) && (w_ra == '0))
            && ({1'b0, w_ra} < DEPTH_EXT)) begin
          w_rd = r_mem[w_ra];
          for (int i = 0; i < NW; i++) begin
            if (w_wen[i] && (w_waddr[i] == w_ra)) begin
              w_rd = w_wdata[i];
            end
          end
        end
      end

      assign rdata[gi*DW +: DW] = w_rd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Two instances: A = default (2R/2W, 32 entries, register 0 hardwired),
// B = 4R/3W, 24 entries, register 0 ordinary. A driver issues stimulus and
// pushes expected values from a behavioural model into a scoreboard queue;
// a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr;

  // Instance A
  logic         ready_a, wr_drop_a;
  logic [1:0]   we_a;
  logic [9:0]   waddr_a;
  logic [63:0]  wdata_a;
  logic [1:0]   re_a;
  logic [9:0]   raddr_a;
  logic [63:0]  rdata_a;

  // Instance B
  logic         ready_b, wr_drop_b;
  logic [2:0]   we_b;
  logic [14:0]  waddr_b;
  logic [95:0]  wdata_b;
  logic [3:0]   re_b;
  logic [19:0]  raddr_b;
  logic [127:0] rdata_b;

  regfile_mp u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_a), .wr_drop(wr_drop_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .re(re_a), .raddr(raddr_a), .rdata(rdata_a)
  );

  regfile_mp #(.DW(32), .AW(5), .DEPTH(24), .NR(4), .NW(3), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_b), .wr_drop(wr_drop_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .re(re_b), .raddr(raddr_b), .rdata(rdata_b)
  );

  // Per-instance configuration
  int NWv  [2] = '{2, 3};
  int NRv  [2] = '{2, 4};
  int DEPv [2] = '{32, 24};
  int ZRv  [2] = '{1, 0};

  // Stimulus, unpacked per instance/port
  logic        s_we    [2][4];
  logic [4:0]  s_waddr [2][4];
  logic [31:0] s_wdata [2][4];
  logic        s_re    [2][4];
  logic [4:0]  s_raddr [2][4];

  always_comb begin
    we_a = '0; waddr_a = '0; wdata_a = '0; re_a = '0; raddr_a = '0;
    we_b = '0; waddr_b = '0; wdata_b = '0; re_b = '0; raddr_b = '0;
    for (int i = 0; i < 2; i++) begin
      we_a[i] = s_we[0][i];
      waddr_a[i*5 +: 5] = s_waddr[0][i];
      wdata_a[i*32 +: 32] = s_wdata[0][i];
      re_a[i] = s_re[0][i];
      raddr_a[i*5 +: 5] = s_raddr[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      we_b[i] = s_we[1][i];
      waddr_b[i*5 +: 5] = s_waddr[1][i];
      wdata_b[i*32 +: 32] = s_wdata[1][i];
    end
    for (int j = 0; j < 4; j++) begin
      re_b[j] = s_re[1][j];
      raddr_b[j*5 +: 5] = s_raddr[1][j];
    end
  end

  // Behavioural model: a running flag, a countdown of clear edges, and the
  // register contents, which become all-zero the moment a clear completes.
  logic [31:0] m_mem  [2][32];
  bit          m_run  [2];
  int          m_left [2];
  bit          m_drop [2];
  bit          m_known;

  typedef struct {
    int          kind;   // 0 rdata, 1 ready, 2 wr_drop
    int          inst;
    int          port;
    logic [31:0] exp;
    string       ph;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  function automatic bit write_ok(int n, int i);
    int a;
    a = int'(s_waddr[n][i]);
    return s_we[n][i] && (a < DEPv[n]) && !(ZRv[n] != 0 && a == 0);
  endfunction

  function automatic logic [31:0] model_read(int n, int j);
    logic [31:0] v;
    int a;
    if (rst || !m_run[n] || !s_re[n][j]) return 32'h0;
    a = int'(s_raddr[n][j]);
    if (ZRv[n] != 0 && a == 0) return 32'h0;
    if (a >= DEPv[n]) return 32'h0;
    v = m_mem[n][a];
    for (int i = 0; i < NWv[n]; i++)
      if (write_ok(n, i) && int'(s_waddr[n][i]) == a) v = s_wdata[n][i];
    return v;
  endfunction

  task automatic model_edge();
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_run[n]  = 1'b0;
        m_left[n] = DEPv[n];
        m_drop[n] = 1'b0;
      end else begin
        bit any_we;
        any_we = 1'b0;
        for (int i = 0; i < NWv[n]; i++) any_we |= s_we[n][i];
        m_drop[n] = any_we && !m_run[n];
        if (m_run[n]) begin
          for (int i = 0; i < NWv[n]; i++)
            if (write_ok(n, i)) m_mem[n][s_waddr[n][i]] = s_wdata[n][i];
          if (clr) begin
            m_run[n]  = 1'b0;
            m_left[n] = DEPv[n];
          end
        end else begin
          m_left[n]--;
          if (m_left[n] == 0) begin
            m_run[n] = 1'b1;
            for (int a = 0; a < 32; a++) m_mem[n][a] = 32'h0;
          end
        end
      end
    end
    if (rst) m_known = 1'b1;
  endtask

  task automatic push_expect();
    for (int n = 0; n < 2; n++) begin
      for (int j = 0; j < NRv[n]; j++)
        sb_q.push_back('{0, n, j, model_read(n, j), phase});
      if (m_known) begin
        sb_q.push_back('{1, n, 0, {31'h0, m_run[n]}, phase});
        sb_q.push_back('{2, n, 0, {31'h0, m_drop[n]}, phase});
      end
    end
  endtask

  // Inputs are held from just after one rising edge until just after the next.
  task automatic step();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++) begin
        s_we[n][i] = 1'b0; s_waddr[n][i] = '0; s_wdata[n][i] = '0;
        s_re[n][i] = 1'b0; s_raddr[n][i] = '0;
      end
    clr = 1'b0;
  endtask

  task automatic set_w(int n, int i, int a, logic [31:0] d);
    s_we[n][i] = 1'b1; s_waddr[n][i] = 5'(a); s_wdata[n][i] = d;
  endtask

  task automatic read_all(int a);
    for (int n = 0; n < 2; n++)
      for (int j = 0; j < 4; j++) begin
        s_re[n][j] = 1'b1; s_raddr[n][j] = 5'(a);
      end
  endtask

  task automatic rand_reads();
    for (int n = 0; n < 2; n++)
      for (int j = 0; j < 4; j++) begin
        s_re[n][j] = 1'b1; s_raddr[n][j] = 5'($urandom_range(0, 31));
      end
  endtask

  task automatic rand_cycle();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++) begin
        s_we[n][i]    = 1'($urandom_range(0, 1));
        s_waddr[n][i] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
        s_wdata[n][i] = $urandom;
        s_re[n][i]    = ($urandom_range(0, 3) != 0);
        s_raddr[n][i] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
      end
    rst = ($urandom_range(0, 199) == 0);
    clr = ($urandom_range(0, 49) == 0);
  endtask

  function automatic logic [31:0] actual(int kind, int n, int j);
    if (kind == 1) return {31'h0, (n == 0) ? ready_a : ready_b};
    if (kind == 2) return {31'h0, (n == 0) ? wr_drop_a : wr_drop_b};
    return (n == 0) ? rdata_a[j*32 +: 32] : rdata_b[j*32 +: 32];
  endfunction

  // Monitor: compare everything queued for this cycle at the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    string       kn;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual(e.kind, e.inst, e.port);
        kn  = (e.kind == 0) ? "rdata" : (e.kind == 1) ? "ready" : "wr_drop";
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s %s inst%0d port%0d got %h want %h",
                   e.ph, kn, e.inst, e.port, act, e.exp);
        end
      end
    end
  end

  initial begin
    m_known = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_run[n] = 1'b0; m_left[n] = 0; m_drop[n] = 1'b0;
      for (int a = 0; a < 32; a++) m_mem[n][a] = 32'h0;
    end
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // T1: reset held, then clear sequence; reads must stay zero until ready.
    phase = "T1_reset";
    rand_reads();
    repeat (2) step();
    rst = 1'b0;
    phase = "T1_clear";
    for (int k = 0; k < 34; k++) begin
      rand_reads();
      step();
    end

    // T2: single write with forwarding, then stored value.
    phase = "T2_fwd";
    idle();
    set_w(0, 0, 5, 32'hDEADBEEF);
    set_w(1, 0, 5, 32'hDEADBEEF);
    read_all(5);
    step();
    phase = "T2_stored";
    idle();
    read_all(5);
    step();

    // T3: collisions, highest port wins both forwarding and storage.
    phase = "T3_coll2";
    idle();
    for (int n = 0; n < 2; n++) begin
      set_w(n, 0, 7, 32'h1);
      set_w(n, 1, 7, 32'h2);
    end
    read_all(7);
    step();
    idle(); read_all(7); step();
    phase = "T3_coll3";
    idle();
    set_w(1, 0, 9, 32'd10);
    set_w(1, 1, 9, 32'd20);
    set_w(1, 2, 9, 32'd30);
    set_w(0, 1, 9, 32'd40);
    set_w(0, 0, 9, 32'd50);
    read_all(9);
    step();
    idle(); read_all(9); step();

    // Out-of-range write/read on the 24-entry instance.
    phase = "oob";
    idle();
    set_w(1, 2, 26, 32'h12345678);
    read_all(26);
    step();
    idle(); read_all(26); step();

    // T4: register 0.
    phase = "T4_zero";
    idle();
    set_w(0, 0, 0, 32'hFFFFFFFF);
    set_w(1, 0, 0, 32'hFFFFFFFF);
    read_all(0);
    step();
    idle(); read_all(0); step();

    // T5: clear request, then a write that must be dropped.
    phase = "T5_clr";
    idle();
    clr = 1'b1;
    read_all(5);
    step();
    idle();
    set_w(0, 0, 5, 32'h0000ABCD);
    set_w(1, 0, 5, 32'h0000ABCD);
    read_all(5);
    step();
    idle();
    for (int k = 0; k < 34; k++) begin
      read_all(5);
      step();
    end

    // T6: reset asserted mid-clear restarts the count.
    phase = "T6_midclr";
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin rand_reads(); step(); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 36; k++) begin rand_reads(); step(); end

    // Randomized traffic.
    phase = "rand";
    for (int k = 0; k < 400; k++) begin
      rand_cycle();
      step();
    end
    rst = 1'b0;
    idle();

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
